// File: rtl/vga_pkg.sv
// Default VGA 640x480@60 timing constants, derived totals and a decode helper
// shared by the timing generator and its output register stage.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Half-open window test [lo, hi) on a 10-bit counter value.
  function automatic logic in_window(input logic [9:0] val,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_out_reg.sv
// Output register stage: registers sync, visible flag and blank-gated colour
// together so every pin carries the same single cycle of latency.
module vga_out_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_next,
  input  logic       vsync_next,
  input  logic       visible,
  input  logic [3:0] red,
  input  logic [3:0] green,
  input  logic [3:0] blue,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b
);

  // Sync idles high (inactive); colour is forced black outside the visible area.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      active <= 1'b0;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else begin
      hsync  <= hsync_next;
      vsync  <= vsync_next;
      active <= visible;
      vga_r  <= visible ? red   : 4'h0;
      vga_g  <= visible ? green : 4'h0;
      vga_b  <= visible ? blue  : 4'h0;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator: pixel/line counters, sync decode and registered outputs.
// Define VGA_FRAME_TICK_EN to add the FrameTick pulse and FrameCount outputs.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       CLK25M,
  input  logic       ResetN,
  output logic [9:0] Hcount,
  output logic [8:0] Vcount,
  input  logic [7:0] RedIn,
  input  logic [7:0] GreenIn,
  input  logic [7:0] BlueIn,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       Active
`ifdef VGA_FRAME_TICK_EN
  ,
  output logic       FrameTick,
  output logic [7:0] FrameCount
`endif
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       visible;
  logic       hsync_next;
  logic       vsync_next;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge CLK25M or negedge ResetN) begin
    if (!ResetN) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  assign Hcount = hcnt;
  // Lines past the visible area report 0 so counts >= 512 cannot alias into 9 bits.
  assign Vcount = (vcnt < V_VIS) ? vcnt[8:0] : 9'd0;

  assign visible    = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign hsync_next = !in_window(hcnt, HS_START, HS_END);
  assign vsync_next = !in_window(vcnt, VS_START, VS_END);

  // The DAC is only 4 bits wide per channel; the low input bits are dropped.
  logic unused_low_bits;
  assign unused_low_bits = ^{RedIn[3:0], GreenIn[3:0], BlueIn[3:0]};

  vga_out_reg u_out_reg (
    .clk        (CLK25M),
    .rst_n      (ResetN),
    .hsync_next (hsync_next),
    .vsync_next (vsync_next),
    .visible    (visible),
    .red        (RedIn[7:4]),
    .green      (GreenIn[7:4]),
    .blue       (BlueIn[7:4]),
    .hsync      (HSYNC),
    .vsync      (VSYNC),
    .active     (Active),
    .vga_r      (VGA_R),
    .vga_g      (VGA_G),
    .vga_b      (VGA_B)
  );

`ifdef VGA_FRAME_TICK_EN
  logic frame_start;
  assign frame_start = (hcnt == 10'd0) && (vcnt == 10'd0);

  // Registered alongside the output stage so the tick lines up with pixel (0,0).
  always_ff @(posedge CLK25M or negedge ResetN) begin
    if (!ResetN) begin
      FrameTick  <= 1'b0;
      FrameCount <= '0;
    end else begin
      FrameTick <= frame_start;
      if (frame_start) FrameCount <= FrameCount + 8'd1;
    end
  end
`endif

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines.
REQ-009 Port CLK25M, input, 1 bit: 25 MHz pixel clock, the only clock.
REQ-010 Port ResetN, input, 1 bit: reset, asynchronous, active-low.
REQ-011 Port Hcount, output, 10 bits: current pixel column.
REQ-012 Port Vcount, output, 9 bits: current visible line.
REQ-013 Port RedIn / GreenIn / BlueIn, input, 8 bits each: pixel colour from the colour stage for the current Hcount/Vcount.
REQ-014 Port VGA_R / VGA_G / VGA_B, output, 4 bits each: pixel colour driven to the DAC pins.
REQ-015 Port HSYNC and VSYNC, output, 1 bit each: sync pulses, active-low.
REQ-016 Port Active, output, 1 bit: high when the registered pixel lies in the visible area.

Function
REQ-017 The horizontal counter hcnt SHALL count 0..H_TOTAL-1 and wrap to 0, where H_TOTAL = sum of the H_* parameters (800 by default).
REQ-018 The vertical counter vcnt (10 bits) SHALL increment only in the cycle hcnt wraps; it SHALL count 0..V_TOTAL-1 (525 by default) and then wrap to 0.
REQ-019 Hcount SHALL equal hcnt combinationally, with no added latency.
REQ-020 Vcount SHALL equal vcnt[8:0] when vcnt < V_ACTIVE; otherwise it SHALL be 0, so that vcnt values of 512 and above never alias.
REQ-021 The combinational visible flag SHALL be (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
REQ-022 The combinational hsync term SHALL be low for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
REQ-023 The combinational vsync term SHALL be low for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC (490..491 by default).
REQ-024 The output stage SHALL register HSYNC, VSYNC, Active and VGA_R/G/B together, giving a latency of exactly 1 cycle from the counter state.
REQ-025 VGA_R/G/B SHALL take RedIn[7:4]/GreenIn[7:4]/BlueIn[7:4] when the visible flag is high, and 0 otherwise.
REQ-026 RGB input values presented during blanking SHALL have no effect on the outputs.

Reset
REQ-027 While ResetN is low: hcnt = 0, vcnt = 0, HSYNC = 1, VSYNC = 1, Active = 0, VGA_R/G/B = 0.
REQ-028 Reset assertion SHALL take effect immediately, including mid-line or mid-sync pulse.
REQ-029 After ResetN deasserts, hcnt SHALL reach 1 on the first rising edge.

Configuration
REQ-030 Macro VGA_FRAME_TICK_EN SHALL control an optional frame-tick feature.
REQ-031 With VGA_FRAME_TICK_EN defined, the block SHALL add output FrameTick (1 bit), a registered one-cycle pulse asserted with the first pixel of each frame (hcnt = 0, vcnt = 0), using the same 1-cycle latency as REQ-024.
REQ-032 With VGA_FRAME_TICK_EN defined, the block SHALL also add output FrameCount (8 bits), which increments on each FrameTick, wraps 255 to 0, and resets to 0.
REQ-033 With VGA_FRAME_TICK_EN undefined, neither port SHALL exist and no logic for them SHALL be generated.

Structure
REQ-034 A shared package vga_pkg SHALL hold the default timing constants and the derived H_TOTAL/V_TOTAL.
REQ-035 The output stage SHALL be a sub-module vga_out_reg that registers the sync signals, Active and gated RGB.
REQ-036 The counters and decode logic SHALL remain in vga_timing.

Verification
REQ-037 Release reset, run 800 cycles: Hcount steps 0..799 then returns to 0, and Vcount changes from 0 to 1 in the same cycle.
REQ-038 Observe one line: HSYNC is low for exactly 96 cycles, starting 1 cycle after Hcount = 656.
REQ-039 Observe one frame (420000 cycles): VSYNC is low for exactly 1600 cycles, starting 1 cycle after the line-490 boundary; the frame period is 420000 cycles.
REQ-040 Drive RedIn = 8'hFF at Hcount = 639 and at Hcount = 640: VGA_R = 4'hF one cycle after 639 and 4'h0 one cycle after 640.
REQ-041 Assert ResetN low at Hcount = 700 (inside the sync pulse): HSYNC = 1 and Hcount = 0 immediately, with no clock edge required.
REQ-042 With VGA_FRAME_TICK_EN defined, run 3 frames: exactly 3 FrameTick pulses occur, spaced 420000 cycles apart, and FrameCount = 3.
